sdp_ram: RTL and testbench
==========================

Name: sdp_ram

Overview:
- Simple dual-port RAM with one write port (A) and one read port (B), one shared clock.
- Used as the per-channel line/frame buffer inside the pooling datapath. One instance per channel, DW = quantized word width, AW = log2(buffer depth).
- Port B reads combinationally by default. An optional registered-output mode adds one cycle of read latency.

Parameters:
- AW, default 8: address width. Depth = 2**AW words.
- DW, default 32: data word width in bits.

Ports:
- clk  input  1  clock; both ports are synchronous to it.
- rstn  input  1  reset, asynchronous, active-low.
- wea  input  1  port A write enable.
- addra  input  AW  port A write address.
- dia  input  DW  port A write data.
- addrb  input  AW  port B read address.
- dob  output  DW  port B read data.

Behaviour:
- Storage: array of 2**AW words, DW bits each.
  - Every address in 0..2**AW-1 is valid; there is no out-of-range case and no internal address wrap logic.
  - Contents are not cleared by rstn and are undefined (X) after power-up.
  - Callers must write a location before reading it.
- Write, port A:
  - At posedge clk with rstn=1 and wea=1, mem[addra] <= dia.
  - With wea=0, memory is unchanged.
  - While rstn=0, writes are suppressed even if wea=1.
  - When rstn is released, writes resume on the next posedge with wea=1.
- Read, port B, default mode (combinational):
  - dob = mem[addrb] at all times, zero cycles of latency.
  - dob follows any change of addrb within the same cycle.
  - A write to the same address becomes visible on dob right after the posedge that performs it.
  - Before that edge, dob shows the old contents.
  - rstn has no effect on dob in this mode.
- Simultaneous write and read to the same address in one cycle:
  - Default mode: dob shows old data until the edge, new data after it.
  - Registered mode: the captured value is the old data (read-first).
- Simultaneous write and read to different addresses: fully independent, no interaction.
- Reset mid-operation: memory contents are preserved through a reset pulse; only the output register (if present) is cleared.
- No handshake, no full/empty flags. Occupancy tracking is the caller's job.
- Synthesis: infer block/distributed RAM. No vendor primitives.

Optional Feature:
- Macro: SDP_RAM_OUTREG_EN.
- Defined:
  - dob is a register loaded at every posedge clk with mem[addrb], using the pre-write contents on collision.
  - Read latency is 1 cycle: address presented in cycle N gives data during cycle N+1.
  - rstn=0 asynchronously forces dob to 0, which holds until the first posedge after release.
- Not defined:
  - Combinational read as described above.
  - No output register exists, and dob has no reset value.

Test Plan:
- Basic write then read: write 0xDEADBEEF to addr 5, then set addrb=5 → dob=0xDEADBEEF (same cycle; next cycle with OUTREG).
- Full-depth sweep, AW=4: write mem[i]=i*3+1 for i=0..15, then read 0..15 → each matches. Address 15 and address 0 are both accessible.
- Collision: mem[7]=0x11, then write 0x22 to addr 7 with addrb=7 in the same cycle.
  - Default mode: dob=0x11 before the edge, 0x22 after it.
  - OUTREG mode: the registered value is 0x11, and 0x22 appears the following cycle.
- Write enable low: wea=0, addra=3, dia=0xFFFF_FFFF, with mem[3]=0x5 → mem[3] still reads 0x5.
- Reset mid-operation: write 0xA5 to addr 2, pulse rstn low for 3 cycles with wea=1 and addra=2, dia=0x00 → mem[2] still reads 0xA5. With OUTREG, dob=0 during reset and 0xA5 one cycle after release.
- Independent ports: write 0x1 to addr 0 while reading addr 9 (mem[9]=0x99) → dob=0x99 unaffected.

Source files
------------

// File: rtl/sdp_ram.sv
// ---------------------------------------------------------------------------
// sdp_ram -- simple dual-port RAM, one write port (A) and one read port (B)
// on a single shared clock. Used as the per-channel line/frame buffer in the
// pooling datapath: DW is the quantized word width, AW = log2(buffer depth).
//
// Build option:
//   SDP_RAM_OUTREG_EN  undefined (default): port B reads combinationally,
//                      dob = mem[addrb] with zero latency.
//                      defined: dob is registered, one cycle of read latency,
//                      read-first on a same-address collision, cleared to 0
//                      asynchronously while rstn is low.
//
// Parameters:
//   AW   address width, depth = 2**AW words
//   DW   data word width in bits
//
// Ports:
//   clk    clock, both ports are synchronous to it
//   rstn   asynchronous active-low reset (suppresses writes, clears the
//          output register when present; never clears the array)
//   wea    port A write enable
//   addra  port A write address
//   dia    port A write data
//   addrb  port B read address
//   dob    port B read data
//
// Interface semantics: there is no valid/ready handshake. Port A accepts a
// write on every posedge where rstn=1 and wea=1; port B is always ready and
// presents data for whatever address is on addrb. Occupancy tracking belongs
// to the caller.
// ---------------------------------------------------------------------------
module sdp_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wea,
  input  logic [AW-1:0] addra,
  input  logic [DW-1:0] dia,
  input  logic [AW-1:0] addrb,
  output logic [DW-1:0] dob
);

  localparam int DEPTH = 2 ** AW;

  // Storage. Deliberately not reset so synthesis can map it onto block or
  // distributed RAM; contents are X until written.
  logic [DW-1:0] mem [DEPTH];

  // Write enable qualified by reset. rstn is used as a plain enable here
  // rather than as an async reset on the array, which keeps the array
  // inferable while still blocking writes for the whole time rstn is low.
  logic write_en;
  assign write_en = rstn & wea;

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[addra] <= dia;
    end
  end

`ifdef SDP_RAM_OUTREG_EN
  // Registered read. The nonblocking write above and this read sample the
  // array at the same edge, so a same-address collision captures the
  // pre-write contents (read-first).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dob <= '0;
    end else begin
      dob <= mem[addrb];
    end
  end
`else
  // Combinational read: follows addrb immediately, and shows a write to the
  // same address right after the edge that performs it.
  assign dob = mem[addrb];
`endif

endmodule

// File: tb/tb_sdp_ram.sv
// ---------------------------------------------------------------------------
// tb_sdp_ram -- directed self-checking bench for sdp_ram (AW=4, DW=32).
// Works in both builds; expected timing follows SDP_RAM_OUTREG_EN.
// Inputs are driven just after the falling edge; outputs are sampled 1 time
// unit after a change (combinational build) or after the rising edge
// (registered build).
// ---------------------------------------------------------------------------
module tb_sdp_ram;

  localparam int AW = 4;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rstn;
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dia;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dob;

  always #5 clk = ~clk;

  sdp_ram #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .wea   (wea),
    .addra (addra),
    .dia   (dia),
    .addrb (addrb),
    .dob   (dob)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a falling edge.
  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wea   = 1'b1;
    addra = a;
    dia   = d;
    @(negedge clk);
    wea   = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] a,
                            input logic [DW-1:0] exp);
    addrb = a;
`ifdef SDP_RAM_OUTREG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
    check(tag, dob, exp);
`ifdef SDP_RAM_OUTREG_EN
    @(negedge clk);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn  = 1'b0;
    wea   = 1'b0;
    addra = '0;
    dia   = '0;
    addrb = '0;
    repeat (2) @(negedge clk);
`ifdef SDP_RAM_OUTREG_EN
    check("reset_dob", dob, 32'h0);
`endif
    rstn = 1'b1;
    @(negedge clk);

    // Basic write then read
    write_word(4'd5, 32'hDEAD_BEEF);
    read_check("basic_rd5", 4'd5, 32'hDEAD_BEEF);

    // Full-depth sweep: mem[i] = i*3+1
    for (int i = 0; i < 16; i++) begin
      write_word(i[AW-1:0], DW'(i * 3 + 1));
      exp_q.push_back(DW'(i * 3 + 1));
    end
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      read_check($sformatf("sweep_rd%0d", i), i[AW-1:0], e);
    end
    // Extremes again, back to back
    read_check("sweep_top", 4'd15, 32'd46);
    read_check("sweep_bot", 4'd0, 32'd1);

`ifndef SDP_RAM_OUTREG_EN
    // Combinational read follows addrb within one cycle
    addrb = 4'd10; #1;
    check("comb_follow_a", dob, 32'd31);
    addrb = 4'd11; #1;
    check("comb_follow_b", dob, 32'd34);
    @(negedge clk);
`endif

    // Collision: mem[7]=0x11, then write 0x22 with addrb=7
    write_word(4'd7, 32'h11);
    addrb = 4'd7;
    wea   = 1'b1;
    addra = 4'd7;
    dia   = 32'h22;
`ifdef SDP_RAM_OUTREG_EN
    @(posedge clk); #1;
    check("coll_regd_old", dob, 32'h11);
    @(negedge clk);
    wea = 1'b0;
    @(posedge clk); #1;
    check("coll_regd_new", dob, 32'h22);
    @(negedge clk);
`else
    #1;
    check("coll_before_edge", dob, 32'h11);
    @(posedge clk); #1;
    check("coll_after_edge", dob, 32'h22);
    @(negedge clk);
    wea = 1'b0;
`endif

    // Write enable low leaves memory unchanged
    write_word(4'd3, 32'h5);
    wea   = 1'b0;
    addra = 4'd3;
    dia   = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    read_check("wea_low", 4'd3, 32'h5);

    // Reset mid-operation: contents preserved, writes suppressed
    write_word(4'd2, 32'hA5);
    addrb = 4'd2;
    rstn  = 1'b0;
    wea   = 1'b1;
    addra = 4'd2;
    dia   = 32'h00;
    #1;
`ifdef SDP_RAM_OUTREG_EN
    check("rst_dob_async", dob, 32'h0);
`else
    check("rst_dob_comb", dob, 32'hA5);
`endif
    repeat (3) @(negedge clk);
`ifdef SDP_RAM_OUTREG_EN
    check("rst_dob_hold", dob, 32'h0);
`else
    check("rst_mem_kept", dob, 32'hA5);
`endif
    rstn = 1'b1;
    wea  = 1'b0;
`ifdef SDP_RAM_OUTREG_EN
    #1;
    check("rst_release_pre", dob, 32'h0);
    @(posedge clk); #1;
    check("rst_release_post", dob, 32'hA5);
    @(negedge clk);
`else
    @(negedge clk);
`endif
    read_check("rst_mem2", 4'd2, 32'hA5);
    // Writes resume after release
    write_word(4'd2, 32'h5A);
    read_check("rst_write_resume", 4'd2, 32'h5A);

    // Independent ports: write addr 0 while reading addr 9
    write_word(4'd9, 32'h99);
    addrb = 4'd9;
    wea   = 1'b1;
    addra = 4'd0;
    dia   = 32'h1;
`ifndef SDP_RAM_OUTREG_EN
    #1;
    check("indep_before", dob, 32'h99);
`endif
    @(posedge clk); #1;
    check("indep_after", dob, 32'h99);
    @(negedge clk);
    wea = 1'b0;
    read_check("indep_wr0", 4'd0, 32'h1);
    read_check("indep_rd9", 4'd9, 32'h99);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
